// File: rtl/array_frame_loader.sv
// Double-buffered row-major frame loader: elements fill a working array and
// the completed frame is copied (optionally column-reversed) into a shadow array.
module array_frame_loader #(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int W    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rev,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROWS*COLS*W-1:0] out_frame,
  output logic                   err
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {FILL, HOLD} state_t;
  typedef logic [ROWS-1:0][COLS-1:0][W-1:0] arr_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  arr_t          fbuf, buf_nx, img, shd;
  logic          flag, copy_flag;
  logic          acc, first, at_end, done, bad, shd_free, copy;

  assign in_ready  = (state == FILL);
  assign out_frame = shd;

  always_comb begin
    acc      = in_valid && in_ready;
    first    = (row == '0) && (col == '0);
    at_end   = (row == RW'(ROWS-1)) && (col == CW'(COLS-1));
    done     = acc && at_end && in_last;
    bad      = acc && (in_last != at_end);
    shd_free = !out_valid || out_ready;
    copy     = (done && shd_free) || (state == HOLD && out_valid && out_ready);
    // A one-element frame completes on its first beat, so the live rev is used then.
    copy_flag = (state == HOLD) ? flag : (first ? rev : flag);
    buf_nx = fbuf;
    if (acc) buf_nx[row][col] = in_data;
    img = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = copy_flag ? buf_nx[r][COLS-1-c] : buf_nx[r][c];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      row       <= '0;
      col       <= '0;
      fbuf      <= '0;
      flag      <= 1'b0;
      shd       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= bad;
      if (acc) begin
        fbuf <= buf_nx;
        if (first) flag <= rev;
        // Completion, framing error and natural wrap all restart at [0][0].
        if (at_end || in_last) begin
          row <= '0;
          col <= '0;
        end else if (col == CW'(COLS-1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (copy) begin
        shd       <= img;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        FILL: if (done && !shd_free) state <= HOLD;
        HOLD: if (out_valid && out_ready) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_array_frame_loader.sv
// Scoreboard bench: driver feeds a frame-level model, monitor pops expected
// frames on each output handshake and expected error pulses on each err.
module tb_array_frame_loader;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int W    = 1;
  localparam int N    = ROWS * COLS;
  localparam int FW   = N * W;

  logic          clk = 0;
  logic          rst_n, rev, in_valid, in_last, in_ready, out_valid, err;
  logic [W-1:0]  in_data;
  logic [FW-1:0] out_frame;
  logic          out_ready, rnd_ready, fixed_ready, rnd_bit;

  array_frame_loader #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .rev(rev), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_frame(out_frame), .err(err)
  );

  always #5 clk = ~clk;

  assign out_ready = rnd_ready ? rnd_bit : fixed_ready;
  initial rnd_bit = 1'b1;
  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int err_exp = 0;
  logic [FW-1:0] exp_q[$];
  logic [W-1:0]  elems[$];
  logic          frev;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Frame-level reference: collect accepted elements, build the expected image on a good frame.
  task automatic model_accept(input logic [W-1:0] d, input logic l, input logic r);
    logic [FW-1:0] f;
    int k;
    if (elems.size() == 0) frev = r;
    elems.push_back(d);
    if (l != (elems.size() == N)) begin
      err_exp++;
      elems.delete();
    end else if (l) begin
      f = '0;
      for (int rr = 0; rr < ROWS; rr++)
        for (int cc = 0; cc < COLS; cc++) begin
          k = rr * COLS + (frev ? (COLS - 1 - cc) : cc);
          f[(rr*COLS+cc)*W +: W] = elems[k];
        end
      exp_q.push_back(f);
      elems.delete();
    end
  endtask

  // Drive one beat; returns 1ns after the accepting edge with in_valid still high.
  task automatic beat(input logic [W-1:0] d, input logic l, input logic r);
    bit ok = 0;
    in_valid = 1; in_data = d; in_last = l; rev = r;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, l, r);
        @(posedge clk); #1;
        ok = 1;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: in_ready stayed 0 for 200 cycles, expected 1");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame4(input logic [3:0] bits, input logic r0, input logic r_rest);
    for (int i = 0; i < 4; i++) beat(bits[i], i == 3, (i == 0) ? r0 : r_rest);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected: got frame %h, expected no frame", out_frame);
      end else check("sb_frame", out_frame, exp_q.pop_front());
    end
    if (rst_n && err) begin
      n_cmp++;
      if (err_exp == 0) begin
        n_bad++;
        $display("FAIL sb_err: got err=1, expected 0");
      end else err_exp--;
    end
  end

  logic ov_before;
  initial begin
    rst_n = 0; rev = 0; in_valid = 0; in_data = '0; in_last = 0;
    rnd_ready = 0; fixed_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_out_valid", FW'(out_valid), '0);
    check("rst_out_frame", out_frame, '0);
    check("rst_err", FW'(err), '0);
    check("rst_in_ready", FW'(in_ready), FW'(1));
    @(posedge clk); #1;

    // Plain load, out_valid one cycle after the last beat
    frame4(4'b1110, 0, 0);
    check("plain_valid", FW'(out_valid), FW'(1));
    check("plain_frame", out_frame, 4'b1110);
    idle(2);

    // Column reversal
    frame4(4'b1110, 1, 1);
    check("rev_frame", out_frame, 4'b1101);
    idle(2);

    // Back-pressure: second frame parks in HOLD, then swaps with out_valid held
    fixed_ready = 0;
    frame4(4'b1110, 0, 0);
    frame4(4'b0001, 0, 0);
    in_valid = 0;
    check("hold_in_ready", FW'(in_ready), '0);
    check("hold_frame", out_frame, 4'b1110);
    fixed_ready = 1;
    @(posedge clk); #1;
    check("swap_valid", FW'(out_valid), FW'(1));
    check("swap_frame", out_frame, 4'b0001);
    idle(2);

    // Early last -> error pulse, output untouched, recovery
    ov_before = out_valid;
    beat(1'b1, 0, 0);
    beat(1'b0, 1, 0);
    in_valid = 0;
    check("err_pulse", FW'(err), FW'(1));
    check("err_ov_kept", FW'(out_valid), FW'(ov_before));
    @(posedge clk); #1;
    check("err_one_cycle", FW'(err), '0);
    frame4(4'b0101, 0, 0);
    idle(2);

    // Reset in mid-frame
    beat(1'b1, 0, 0); beat(1'b0, 0, 0); beat(1'b1, 0, 0);
    in_valid = 0; rst_n = 0;
    @(posedge clk); #1;
    check("midrst_valid", FW'(out_valid), '0);
    check("midrst_frame", out_frame, '0);
    elems.delete(); exp_q.delete();
    rst_n = 1;
    frame4(4'b0111, 0, 0);
    check("postrst_frame", out_frame, 4'b0111);
    idle(2);

    // rev toggled after the first beat is ignored
    frame4(4'b1110, 0, 1);
    check("revmid_frame", out_frame, 4'b1110);
    idle(2);

    // Randomized traffic with random back-pressure, mid-frame rev and framing errors
    rnd_ready = 1;
    for (int f = 0; f < 300; f++) begin
      int len;
      bit drop_last;
      len = N; drop_last = 0;
      case ($urandom_range(0, 19))
        0, 1: len = $urandom_range(1, N - 1);
        2:    drop_last = 1;
        default: ;
      endcase
      for (int i = 0; i < len; i++) begin
        beat(W'($urandom), (i == len - 1) && !drop_last, 1'($urandom));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    in_valid = 0;
    if (elems.size() != 0) frame4(4'b0000, 0, 0);
    rnd_ready = 0; fixed_ready = 1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    idle(3);
    check("drain_frames", FW'(exp_q.size()), '0);
    check("drain_errs", FW'(err_exp), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
